// File: rtl/ntt_batch_ctrl.sv
// Batch sequencer for the NTT/INTT engine: loads 64 coefficients plus a seed per
// polynomial into BRAM port a, starts the engine and waits for done. Optional watchdog: NTT_WDOG_EN.
module ntt_batch_ctrl #(
    parameter int K           = 4,
    parameter int L           = 4,
    parameter int NCOEF       = 64,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_mode,
    input  logic [4:0]   cmd_count,
    input  logic         cmd_abort,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [131:0] in_data,
    output logic         ram_wea,
    output logic [5:0]   ram_addra,
    output logic [131:0] ram_dia,
    input  logic [5:0]   eng_addra,
    output logic         eng_start,
    output logic [2:0]   eng_mode,
    input  logic         eng_done,
    output logic         seed_valid,
    output logic [15:0]  seed,
    output logic [4:0]   poly_idx,
    output logic         busy,
    output logic         batch_done,
    output logic         err
);

    localparam logic [4:0] MAX_POLY = 5'(K * L);

    // Handshakes: a transfer happens in any cycle where valid and ready are both
    // high at the rising edge; valid never waits for ready, ready only reflects state.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_DONE
`ifdef NTT_WDOG_EN
        , S_TIMEOUT
`endif
    } state_t;

    state_t      state, state_d;
    logic [6:0]  ld_cnt;
    logic [4:0]  cnt_lat;
    logic        last_poly;
    logic        abort_hit;
    logic        wdog_hit;

    assign last_poly = (poly_idx == cnt_lat - 5'd1);
    assign abort_hit = cmd_abort && (state != S_IDLE);
    assign busy      = (state != S_IDLE);
    assign ram_dia   = in_data;

`ifdef NTT_WDOG_EN
    logic [12:0] wdog_cnt;
    logic        err_q;

    assign wdog_hit = (state == S_RUN) && (wdog_cnt == 13'(WDOG_CYCLES - 1));
    assign err      = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == S_START)
                wdog_cnt <= '0;
            else if (state == S_RUN)
                wdog_cnt <= wdog_cnt + 13'd1;
            // err is sticky until a new batch is accepted
            if (state == S_IDLE && cmd_valid)
                err_q <= 1'b0;
            else if (wdog_hit && !eng_done && !abort_hit)
                err_q <= 1'b1;
        end
    end
`else
    assign wdog_hit = 1'b0;
    assign err      = 1'b0;
`endif

    always_comb begin
        state_d    = state;
        cmd_ready  = 1'b0;
        in_ready   = 1'b0;
        ram_wea    = 1'b0;
        ram_addra  = '0;
        eng_start  = 1'b0;
        seed_valid = 1'b0;
        batch_done = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_d = (cmd_count == 5'd0) ? S_DONE : S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (ld_cnt < 7'(NCOEF)) begin
                        ram_wea   = 1'b1;
                        ram_addra = ld_cnt[5:0];
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                eng_start  = 1'b1;
                seed_valid = 1'b1;
                ram_addra  = eng_addra;
                state_d    = S_RUN;
            end
            S_RUN: begin
                ram_addra = eng_addra;
                if (eng_done)
                    state_d = last_poly ? S_DONE : S_LOAD;
`ifdef NTT_WDOG_EN
                else if (wdog_hit)
                    state_d = S_TIMEOUT;
`endif
            end
            S_DONE: begin
                batch_done = 1'b1;
                state_d    = S_IDLE;
            end
`ifdef NTT_WDOG_EN
            S_TIMEOUT: state_d = S_DONE;
`endif
            default: state_d = S_IDLE;
        endcase
        if (abort_hit)
            state_d = S_IDLE;
        // Reset wins the cycle: nothing may be written or started while it is high
        if (rst) begin
            in_ready   = 1'b0;
            ram_wea    = 1'b0;
            eng_start  = 1'b0;
            seed_valid = 1'b0;
            batch_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ld_cnt   <= '0;
            cnt_lat  <= '0;
            poly_idx <= '0;
            seed     <= '0;
            eng_mode <= '0;
        end else begin
            state <= state_d;
            if (!abort_hit) begin
                case (state)
                    S_IDLE: if (cmd_valid) begin
                        eng_mode <= cmd_mode;
                        cnt_lat  <= (cmd_count > MAX_POLY) ? MAX_POLY : cmd_count;
                        poly_idx <= '0;
                        ld_cnt   <= '0;
                    end
                    S_LOAD: if (in_valid) begin
                        if (ld_cnt < 7'(NCOEF))
                            ld_cnt <= ld_cnt + 7'd1;
                        else
                            seed <= in_data[15:0];
                    end
                    S_RUN: if (eng_done && !last_poly) begin
                        poly_idx <= poly_idx + 5'd1;
                        ld_cnt   <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ntt_batch_ctrl.sv
// Bench for ntt_batch_ctrl: table of batch commands plus hand-written sequences
// for backpressure, address mux, abort, mid-load reset and the engine-done watchdog.
module tb_ntt_batch_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_mode;
    logic [4:0]   cmd_count;
    logic         cmd_abort;
    logic         in_valid;
    logic         in_ready;
    logic [131:0] in_data;
    logic         ram_wea;
    logic [5:0]   ram_addra;
    logic [131:0] ram_dia;
    logic [5:0]   eng_addra;
    logic         eng_start;
    logic [2:0]   eng_mode;
    logic         eng_done;
    logic         seed_valid;
    logic [15:0]  seed;
    logic [4:0]   poly_idx;
    logic         busy;
    logic         batch_done;
    logic         err;

    logic         model_done;
    logic         spur_done;
    int           eng_lat;
    int           eng_timer;

    int total = 0;
    int bad   = 0;
    int start_cnt;
    int done_cnt;
    logic [137:0] exp_q[$];

    assign eng_done = model_done | spur_done;

    ntt_batch_ctrl #(.K(4), .L(4), .NCOEF(64), .WDOG_CYCLES(50)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_count(cmd_count), .cmd_abort(cmd_abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dia(ram_dia),
        .eng_addra(eng_addra), .eng_start(eng_start), .eng_mode(eng_mode),
        .eng_done(eng_done), .seed_valid(seed_valid), .seed(seed),
        .poly_idx(poly_idx), .busy(busy), .batch_done(batch_done), .err(err)
    );

    // clock / time guard
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // engine model: done pulse eng_lat cycles after start (0 = never)
    initial begin
        model_done = 1'b0;
        eng_timer  = 0;
        forever begin
            @(posedge clk);
            #1;
            model_done = 1'b0;
            if (eng_timer > 0) begin
                eng_timer--;
                if (eng_timer == 0) model_done = 1'b1;
            end
            if (eng_start) eng_timer = eng_lat;
        end
    end

    // scoreboard / monitor
    always @(negedge clk) begin
        if (ram_wea) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {126'd0, ram_addra}, 132'h0);
                total--;
                if (ram_addra == 6'd0) begin
                    bad++;
                    $display("FAIL unexpected_write: got addr 0 want no write");
                end
            end else begin
                logic [137:0] e;
                e = exp_q.pop_front();
                chk("write_addr", {126'd0, ram_addra}, {126'd0, e[137:132]});
                chk("write_data", ram_dia, e[131:0]);
            end
        end
        if (eng_start) begin
            chk("seed_valid_with_start", {131'd0, seed_valid}, 132'd1);
            chk("poly_idx_at_start", {127'd0, poly_idx}, 132'(start_cnt));
            start_cnt++;
        end
        if (batch_done) done_cnt++;
    end

    // driver tasks: all drive at posedge+1, return at posedge+1
    task automatic issue_cmd(input logic [4:0] cnt, input logic [2:0] mode);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_count = cnt;
        cmd_mode  = mode;
        @(negedge clk);
        while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
        chk("cmd_handshake", {131'd0, cmd_ready}, 132'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [131:0] d, input bit is_seed);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 1000) begin @(negedge clk); n++; end
        if (!in_ready) chk("beat_timeout", {131'd0, in_ready}, 132'd1);
        if (is_seed) chk("no_write_on_seed", {131'd0, ram_wea}, 132'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_poly(input bit gaps, input bit spur);
        logic [131:0] d;
        d = '0;
        for (int b = 0; b <= 64; b++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            d = gaps ? {$urandom, $urandom, $urandom, $urandom, 4'($urandom)} : 132'(b);
            if (b < 64) exp_q.push_back({6'(b), d});
            if (spur && b == 10) begin
                spur_done = 1'b1;
                @(negedge clk);
                chk("spur_done_in_ready", {131'd0, in_ready}, 132'd1);
                @(posedge clk); #1;
                spur_done = 1'b0;
            end
            send_beat(d, b == 64);
        end
        @(negedge clk);
        chk("start_after_seed", {131'd0, eng_start}, 132'd1);
        chk("seed_latched", {116'd0, seed}, {116'd0, d[15:0]});
        @(posedge clk); #1;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 2000) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_after_done", {131'd0, cmd_ready}, 132'd1);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rv_cmd_ready", {131'd0, cmd_ready}, 132'd1);
        chk("rv_busy", {131'd0, busy}, 132'd0);
        chk("rv_in_ready", {131'd0, in_ready}, 132'd0);
        chk("rv_ram_wea", {131'd0, ram_wea}, 132'd0);
        chk("rv_ram_addra", {126'd0, ram_addra}, 132'd0);
        chk("rv_eng_start", {130'd0, eng_start, seed_valid}, 132'd0);
        chk("rv_batch_done", {131'd0, batch_done}, 132'd0);
        chk("rv_err", {131'd0, err}, 132'd0);
        chk("rv_poly_idx", {127'd0, poly_idx}, 132'd0);
        chk("rv_seed", {116'd0, seed}, 132'd0);
        chk("rv_eng_mode", {129'd0, eng_mode}, 132'd0);
    endtask

    typedef struct {
        logic [4:0] count;
        logic [2:0] mode;
        int         exp_starts;
        int         exp_pidx;
        bit         gaps;
    } vec_t;

    vec_t vecs[5];

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_mode = '0; cmd_count = '0; cmd_abort = 1'b0;
        in_valid = 1'b0; in_data = '0; eng_addra = '0; spur_done = 1'b0;
        eng_lat = 100; start_cnt = 0; done_cnt = 0;

        vecs[0] = '{count: 5'd2,  mode: 3'd0, exp_starts: 2,  exp_pidx: 1,  gaps: 1'b0};
        vecs[1] = '{count: 5'd20, mode: 3'd3, exp_starts: 16, exp_pidx: 15, gaps: 1'b0};
        vecs[2] = '{count: 5'd1,  mode: 3'd7, exp_starts: 1,  exp_pidx: 0,  gaps: 1'b1};
        vecs[3] = '{count: 5'd0,  mode: 3'd4, exp_starts: 0,  exp_pidx: 0,  gaps: 1'b0};
        vecs[4] = '{count: 5'd2,  mode: 3'd2, exp_starts: 2,  exp_pidx: 1,  gaps: 1'b1};

        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk); #1;

        // zero-count batch: pulse in the cycle right after the handshake, no start
        start_cnt = 0; done_cnt = 0;
        issue_cmd(5'd0, 3'd1);
        @(negedge clk);
        chk("zero_cnt_done_next", {131'd0, batch_done}, 132'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("zero_cnt_done_once", {131'd0, batch_done}, 132'd0);
        chk("zero_cnt_idle", {131'd0, cmd_ready}, 132'd1);
        chk("zero_cnt_no_start", 132'(start_cnt), 132'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            start_cnt = 0; done_cnt = 0;
            issue_cmd(vecs[i].count, vecs[i].mode);
            for (int p = 0; p < vecs[i].exp_starts; p++) send_poly(vecs[i].gaps, 1'b0);
            wait_done();
            chk("vec_starts", 132'(start_cnt), 132'(vecs[i].exp_starts));
            chk("vec_done_pulses", 132'(done_cnt), 132'd1);
            chk("vec_eng_mode", {129'd0, eng_mode}, {129'd0, vecs[i].mode});
            chk("vec_last_pidx", {127'd0, poly_idx}, 132'(vecs[i].exp_pidx));
            chk("vec_writes_left", 132'(exp_q.size()), 132'd0);
        end

        // address mux, ignored loader/command in RUN, spurious done in LOAD
        start_cnt = 0; done_cnt = 0;
        issue_cmd(5'd2, 3'd1);
        send_poly(1'b0, 1'b1);
        eng_addra = 6'h2A; in_valid = 1'b1; cmd_valid = 1'b1; cmd_mode = 3'd6; cmd_count = 5'd0;
        @(negedge clk);
        chk("mux_addr_run", {126'd0, ram_addra}, 132'h2A);
        chk("mux_wea_run", {131'd0, ram_wea}, 132'd0);
        chk("run_in_ready", {131'd0, in_ready}, 132'd0);
        chk("run_cmd_ready", {131'd0, cmd_ready}, 132'd0);
        @(posedge clk); #1;
        eng_addra = 6'h00; in_valid = 1'b0; cmd_valid = 1'b0;
        send_poly(1'b0, 1'b0);
        wait_done();
        chk("mux_mode_kept", {129'd0, eng_mode}, 132'd1);
        chk("mux_starts", 132'(start_cnt), 132'd2);
        chk("mux_done_pulses", 132'(done_cnt), 132'd1);

        // abort during RUN of polynomial 1
        start_cnt = 0; done_cnt = 0;
        issue_cmd(5'd3, 3'd2);
        send_poly(1'b0, 1'b0);
        send_poly(1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        cmd_abort = 1'b1;
        @(negedge clk);
        chk("abort_busy_before", {131'd0, busy}, 132'd1);
        @(posedge clk); #1;
        cmd_abort = 1'b0;
        @(negedge clk);
        chk("abort_idle", {131'd0, cmd_ready}, 132'd1);
        chk("abort_no_done", {131'd0, batch_done}, 132'd0);
        repeat (120) @(negedge clk);
        chk("abort_late_done_ignored", {131'd0, busy}, 132'd0);
        chk("abort_done_pulses", 132'(done_cnt), 132'd0);
        chk("abort_starts", 132'(start_cnt), 132'd2);
        @(posedge clk); #1;

        // reset while beat 10 is offered
        start_cnt = 0; done_cnt = 0;
        issue_cmd(5'd1, 3'd5);
        for (int b = 0; b < 10; b++) begin
            exp_q.push_back({6'(b), 132'(b)});
            send_beat(132'(b), 1'b0);
        end
        in_valid = 1'b1; in_data = 132'd10; rst = 1'b1;
        @(negedge clk);
        chk("rst_cycle_no_write", {131'd0, ram_wea}, 132'd0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk); #1;

        // engine done withheld
        eng_lat = 0; start_cnt = 0; done_cnt = 0;
        issue_cmd(5'd1, 3'd3);
        send_poly(1'b0, 1'b0);
`ifdef NTT_WDOG_EN
        repeat (50) @(negedge clk);
        chk("wdog_err_before", {131'd0, err}, 132'd0);
        chk("wdog_busy_before", {131'd0, busy}, 132'd1);
        @(negedge clk);
        chk("wdog_err_set", {131'd0, err}, 132'd1);
        chk("wdog_timeout_no_done", {131'd0, batch_done}, 132'd0);
        @(negedge clk);
        chk("wdog_batch_done", {131'd0, batch_done}, 132'd1);
        @(negedge clk);
        chk("wdog_idle", {131'd0, cmd_ready}, 132'd1);
        chk("wdog_err_sticky", {131'd0, err}, 132'd1);
        @(posedge clk); #1;
        done_cnt = 0;
        issue_cmd(5'd0, 3'd0);
        @(negedge clk);
        chk("wdog_err_cleared", {131'd0, err}, 132'd0);
        wait_done();
`else
        repeat (60) @(negedge clk);
        chk("nowdog_err", {131'd0, err}, 132'd0);
        chk("nowdog_still_busy", {131'd0, busy}, 132'd1);
        chk("nowdog_no_done", 132'(done_cnt), 132'd0);
        @(posedge clk); #1;
        cmd_abort = 1'b1;
        @(posedge clk); #1;
        cmd_abort = 1'b0;
        @(negedge clk);
        chk("nowdog_abort_idle", {131'd0, cmd_ready}, 132'd1);
        @(posedge clk); #1;
`endif
        eng_lat = 100;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

●
